// File: rtl/emif_amm_mux_if.sv
// Channel-side and EMIF-side Avalon-MM bundle for emif_amm_mux.
// Handshake: a command transfers in any cycle where request (read/write) and ready are both high; masters hold every field stable while ready is low.
interface emif_amm_mux_if #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 576,
    parameter int BURST_W = 7
);
    logic [NUM_CH-1:0]          ch_read;
    logic [NUM_CH-1:0]          ch_write;
    logic [NUM_CH*ADDR_W-1:0]   ch_address;
    logic [NUM_CH*DATA_W-1:0]   ch_writedata;
    logic [NUM_CH*BURST_W-1:0]  ch_burstcount;
    logic [NUM_CH*DATA_W/8-1:0] ch_byteenable;
    logic [NUM_CH-1:0]          ch_ready;
    logic [DATA_W-1:0]          ch_readdata;
    logic [NUM_CH-1:0]          ch_readdatavalid;

    logic                       amm_ready;
    logic                       amm_read;
    logic                       amm_write;
    logic [ADDR_W-1:0]          amm_address;
    logic [DATA_W-1:0]          amm_writedata;
    logic [BURST_W-1:0]         amm_burstcount;
    logic [DATA_W/8-1:0]        amm_byteenable;
    logic [DATA_W-1:0]          amm_readdata;
    logic                       amm_readdatavalid;

    modport slave (
        input  ch_read, ch_write, ch_address, ch_writedata, ch_burstcount, ch_byteenable,
        input  amm_ready, amm_readdata, amm_readdatavalid,
        output ch_ready, ch_readdata, ch_readdatavalid,
        output amm_read, amm_write, amm_address, amm_writedata, amm_burstcount, amm_byteenable
    );

    modport master (
        output ch_read, ch_write, ch_address, ch_writedata, ch_burstcount, ch_byteenable,
        output amm_ready, amm_readdata, amm_readdatavalid,
        input  ch_ready, ch_readdata, ch_readdatavalid,
        input  amm_read, amm_write, amm_address, amm_writedata, amm_burstcount, amm_byteenable
    );
endinterface

// File: rtl/emif_amm_mux.sv
// N-channel round-robin Avalon-MM arbiter into one EMIF port, with write-burst locking and an in-order read tag FIFO.
// Define EMIF_AMM_MUX_PERF_EN to build the per-channel command counters; otherwise perf_cmd_cnt reads 0.
module emif_amm_mux #(
    parameter int NUM_CH        = 4,
    parameter int ADDR_W        = 27,
    parameter int DATA_W        = 576,
    parameter int BURST_W       = 7,
    parameter int RD_FIFO_DEPTH = 16
) (
    input  logic                 emif_usr_clk,
    input  logic                 emif_usr_reset,
    emif_amm_mux_if.slave        bus,
    output logic                 rd_fifo_full,
    output logic                 rd_unexpected,
    output logic [NUM_CH*32-1:0] perf_cmd_cnt,
    output logic                 fsm_state
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, WR_BURST = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CH_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]    lock_ch, lock_ch_nxt;
    logic [BURST_W-1:0] beats_left, beats_left_nxt;

    logic [NUM_CH-1:0]  req;
    logic [CH_W-1:0]    grant, grant_inc;
    logic               grant_vld, is_write, accept, push;
    logic [BURST_W-1:0] grant_bc, eff_bc;

    logic [CH_W-1:0]    tag_id  [RD_FIFO_DEPTH];
    logic [BURST_W-1:0] tag_len [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic [BURST_W-1:0] rd_beat;
    logic               fifo_empty, rd_hit, pop;

    assign fsm_state = (state == WR_BURST);

    // Reverse scan so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        req       = (bus.ch_write | (bus.ch_read & ~{NUM_CH{rd_fifo_full}})) & {NUM_CH{~emif_usr_reset}};
        grant     = lock_ch;
        grant_vld = 1'b0;
        if (state == WR_BURST) begin
            grant_vld = bus.ch_write[lock_ch] & ~emif_usr_reset;
        end else begin
            grant = '0;
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (req[(int'(rr_ptr) + k) % NUM_CH]) begin
                    grant     = CH_W'((int'(rr_ptr) + k) % NUM_CH);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign is_write  = bus.ch_write[grant];
    assign accept    = grant_vld & bus.amm_ready;
    assign grant_bc  = bus.ch_burstcount[int'(grant)*BURST_W +: BURST_W];
    assign eff_bc    = (grant_bc == '0) ? BURST_W'(1) : grant_bc;
    assign grant_inc = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.amm_read       = 1'b0;
        bus.amm_write      = 1'b0;
        bus.amm_address    = '0;
        bus.amm_writedata  = '0;
        bus.amm_burstcount = '0;
        bus.amm_byteenable = '0;
        bus.ch_ready       = '0;
        if (grant_vld) begin
            bus.amm_read        = ~is_write;
            bus.amm_write       = is_write;
            bus.amm_address     = bus.ch_address[int'(grant)*ADDR_W +: ADDR_W];
            bus.amm_writedata   = bus.ch_writedata[int'(grant)*DATA_W +: DATA_W];
            bus.amm_burstcount  = grant_bc;
            bus.amm_byteenable  = bus.ch_byteenable[int'(grant)*BE_W +: BE_W];
            bus.ch_ready[grant] = bus.amm_ready;
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_ch_nxt    = lock_ch;
        beats_left_nxt = beats_left;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_write) begin
                        push       = 1'b1;
                        rr_ptr_nxt = grant_inc;
                    end else if (eff_bc == BURST_W'(1)) begin
                        rr_ptr_nxt = grant_inc;
                    end else begin
                        lock_ch_nxt    = grant;
                        beats_left_nxt = eff_bc - 1'b1;
                        state_nxt      = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (accept) begin
                    beats_left_nxt = beats_left - 1'b1;
                    if (beats_left == BURST_W'(1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge emif_usr_clk) begin
        if (emif_usr_reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_ch    <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_ch    <= lock_ch_nxt;
            beats_left <= beats_left_nxt;
        end
    end

    // Tag FIFO: one entry per read burst, retired after its last returned beat.
    assign fifo_empty   = (count == '0);
    assign rd_fifo_full = (count == (PTR_W+1)'(RD_FIFO_DEPTH));
    assign rd_hit       = bus.amm_readdatavalid & ~fifo_empty & ~emif_usr_reset;
    assign pop          = rd_hit & (rd_beat == tag_len[rd_ptr] - 1'b1);

    always_comb begin
        bus.ch_readdatavalid = '0;
        bus.ch_readdata      = '0;
        if (rd_hit) begin
            bus.ch_readdatavalid[tag_id[rd_ptr]] = 1'b1;
            bus.ch_readdata                      = bus.amm_readdata;
        end
    end

    always_ff @(posedge emif_usr_clk) begin
        if (push) begin
            tag_id[wr_ptr]  <= grant;
            tag_len[wr_ptr] <= eff_bc;
        end
    end

    always_ff @(posedge emif_usr_clk) begin
        if (emif_usr_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_beat       <= '0;
            rd_unexpected <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (rd_hit) rd_beat <= pop ? '0 : rd_beat + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            if (bus.amm_readdatavalid && fifo_empty) rd_unexpected <= 1'b1;
        end
    end

`ifdef EMIF_AMM_MUX_PERF_EN
    logic        cmd_done;
    logic [31:0] perf_q [NUM_CH];

    // A read counts when accepted; a write counts once, on its final beat.
    assign cmd_done = accept & ((state == IDLE) ? (~is_write | (eff_bc == BURST_W'(1)))
                                                : (beats_left == BURST_W'(1)));

    always_ff @(posedge emif_usr_clk) begin
        if (emif_usr_reset) begin
            for (int i = 0; i < NUM_CH; i++) perf_q[i] <= '0;
        end else if (cmd_done && perf_q[grant] != 32'hFFFF_FFFF) begin
            perf_q[grant] <= perf_q[grant] + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) perf_cmd_cnt[i*32 +: 32] = perf_q[i];
    end
`else
    assign perf_cmd_cnt = '0;
`endif
endmodule

// File: doc/emif_amm_mux.md
Name: emif_amm_mux

Overview:
- Parametrised N-channel Avalon-MM arbiter feeding a single EMIF ctrl_amm port; sits in mc_top between user masters and the EMIF instance, all in the emif_usr_clk domain.
- Round-robin arbitration at burst granularity, with write-burst locking.
- Read-return routing through an in-order tag FIFO.
- Generalises the single-master amm port to NUM_CH masters.

Parameters:
- NUM_CH, 4, number of upstream master channels (2..8).
- ADDR_W, 27, word address width.
- DATA_W, 576, data width; byteenable width is DATA_W/8.
- BURST_W, 7, burstcount width.
- RD_FIFO_DEPTH, 16, outstanding read-burst tags (power of 2).

Ports:
- emif_usr_clk  in  1  sole clock.
- emif_usr_reset  in  1  synchronous, active-high reset.
- ch_read  in  NUM_CH  per-channel read request.
- ch_write  in  NUM_CH  per-channel write request (one per beat).
- ch_address  in  NUM_CH*ADDR_W  packed; channel i at [i*ADDR_W +: ADDR_W].
- ch_writedata  in  NUM_CH*DATA_W  packed write data.
- ch_burstcount  in  NUM_CH*BURST_W  packed burst length.
- ch_byteenable  in  NUM_CH*DATA_W/8  packed byte enables.
- ch_ready  out  NUM_CH  per-channel waitrequest_n.
- ch_readdata  out  DATA_W  read data, broadcast to all channels.
- ch_readdatavalid  out  NUM_CH  one-hot read-data qualifier.
- amm_ready  in  1  EMIF waitrequest_n.
- amm_read  out  1  read request to EMIF.
- amm_write  out  1  write request to EMIF.
- amm_address  out  ADDR_W  address to EMIF.
- amm_writedata  out  DATA_W  write data to EMIF.
- amm_burstcount  out  BURST_W  burst length to EMIF.
- amm_byteenable  out  DATA_W/8  byte enables to EMIF.
- amm_readdata  in  DATA_W  read data from EMIF.
- amm_readdatavalid  in  1  read-data valid from EMIF.
- rd_fifo_full  out  1  tag FIFO full; reads are stalled.
- rd_unexpected  out  1  sticky: readdatavalid arrived with no outstanding tag.
- perf_cmd_cnt  out  NUM_CH*32  per-channel accepted-command counters.

Behaviour:
- Reset state:
  - All outputs 0; grant invalid; state IDLE; round-robin pointer 0; tag FIFO empty; beat counters 0.
  - Reset mid-burst abandons the burst. Read data returning after reset raises rd_unexpected.
- Request per channel: req[i] = ch_write[i] | (ch_read[i] & ~rd_fifo_full). If a channel asserts both, the write wins.
- IDLE:
  - Grant goes combinationally to the first requesting channel at or after the round-robin pointer.
  - The granted channel's fields are muxed onto amm_*.
  - ch_ready[g] = amm_ready; every other ch_ready is 0.
  - No request: amm_read = amm_write = 0.
- Read accept (amm_read & amm_ready):
  - Push {g, burstcount} into the tag FIFO.
  - Pointer advances to g+1 mod NUM_CH.
  - Stay in IDLE.
- Write first beat accept:
  - burstcount ≤ 1 (0 treated as 1): pointer advances to g+1; stay in IDLE.
  - Otherwise latch g, set beats_left = burstcount-1, go to WR_BURST.
- WR_BURST:
  - Grant is locked to the latched channel; other requests are ignored.
  - Each accepted beat decrements beats_left.
  - The accept that brings beats_left to 0 returns to IDLE and advances the pointer.
  - Reads from the locked channel are not serviced until the burst completes.
- Channel contract: masters hold all fields stable while ch_ready is low (standard Avalon). The block registers no command fields: zero-latency muxing, one arbitration decision per cycle.
- Read return:
  - On amm_readdatavalid: ch_readdata = amm_readdata; ch_readdatavalid[head.id] = 1 in the same cycle; rd_beat increments.
  - When rd_beat == head.burst-1, pop and clear rd_beat.
  - Order is strictly in-order, matching EMIF in-order return.
- Boundaries:
  - Push is blocked while full, even if a pop happens the same cycle.
  - Same-cycle push and pop when not full is legal; occupancy is unchanged.
  - readdatavalid with the FIFO empty: data dropped, rd_unexpected set until reset.
  - Round-robin pointer wraps NUM_CH-1 → 0.
- perf_cmd_cnt[i] increments once per accepted read command and once per completed write burst. It saturates at 0xFFFFFFFF.

Optional Feature:
- EMIF_AMM_MUX_PERF_EN defined: perf_cmd_cnt counters are implemented as described.
- Not defined: perf_cmd_cnt is tied to 0 and no counter logic is synthesised; the port still exists.

Test Plan:
- Single-channel read: ch0 read, addr 0x100, burst 4 → amm_read with addr 0x100; 4 readdatavalid beats → ch_readdatavalid = 4'b0001 for 4 cycles, then FIFO empty.
- Round-robin fairness: ch0..ch3 all read burst 1 continuously, amm_ready = 1 → grants in order 0,1,2,3,0; each perf_cmd_cnt = 2 after 8 cycles.
- Write lock: ch1 write burst 8 with amm_ready toggling 1,0 and ch2 requesting → ch2 ready stays 0 until the 8th ch1 beat is accepted; ch2 is granted the next cycle.
- FIFO full: 16 read bursts of 2 with no return data → rd_fifo_full = 1 and the 17th read stalls; return 2 beats → full deasserts and the 17th is accepted.
- Unexpected data: readdatavalid pulsed with the FIFO empty → rd_unexpected = 1, ch_readdatavalid = 0, stays set until emif_usr_reset.
- Reset mid WR_BURST: reset after beat 3 of 8 → next cycle all outputs 0; ch0 burst-1 write is then granted normally.
